// File: rtl/text_ram_arbiter.sv
// Text RAM arbiter: video reads win, host writes queue in a FIFO and drain in the write window.
// Optional macro VIDEO_IDLE_WRITE_EN also drains writes in any cycle without a video request.
module text_ram_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic              i_pix_clk,
  input  logic              i_reset_n,
  input  logic              i_horz_blank,
  input  logic              i_vert_blank,
  input  logic              i_vid_rd_req,
  input  logic [ADDR_W-1:0] i_vid_rd_addr,
  output logic              o_vid_rd_valid,
  output logic [DATA_W-1:0] o_vid_rd_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_flush,
  output logic [LW-1:0]     o_fifo_level,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  logic [ADDR_W-1:0] fa [FIFO_DEPTH];
  logic [DATA_W-1:0] fd [FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [LW-1:0]     level, level_nxt;
  logic              rd_p1;
  logic              win, empty, pop, push;

  always_comb begin
`ifdef VIDEO_IDLE_WRITE_EN
    win = i_horz_blank | i_vert_blank | !i_vid_rd_req;
`else
    win = i_horz_blank | i_vert_blank;
`endif
    empty = (level == '0);
    pop   = !i_vid_rd_req & !empty & win & !i_flush;
    push  = i_wr_valid & o_wr_ready & !i_flush;
    if (i_flush) level_nxt = '0;
    else level_nxt = level + LW'(push) - LW'(pop);
  end

  always_comb begin
    o_ram_we    = pop;
    o_ram_wdata = fd[rp];
    if (i_vid_rd_req) o_ram_addr = i_vid_rd_addr;
    else if (empty) o_ram_addr = '0;
    else o_ram_addr = fa[rp];
  end

  assign o_fifo_level = level;

  always_ff @(posedge i_pix_clk) begin
    if (push) begin
      fa[wp] <= i_wr_addr;
      fd[wp] <= i_wr_data;
    end
  end

  // ready is registered from the next level, so a pop from full frees it one cycle later
  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wp         <= '0;
      rp         <= '0;
      level      <= '0;
      o_wr_ready <= 1'b0;
    end else begin
      level      <= level_nxt;
      o_wr_ready <= (level_nxt != LW'(FIFO_DEPTH));
      if (i_flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
      end
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_p1          <= 1'b0;
      o_vid_rd_valid <= 1'b0;
      o_vid_rd_data  <= '0;
    end else begin
      rd_p1          <= i_vid_rd_req;
      o_vid_rd_valid <= rd_p1;
      if (rd_p1) o_vid_rd_data <= i_ram_rdata;
    end
  end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Randomized bench for text_ram_arbiter against a queue-based reference model.
// Includes a synchronous-read RAM and a directed mid-operation reset.
module tb_text_ram_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hb, vb, req, wr_valid, flush;
  logic [AW-1:0] raddr, wa;
  logic [DW-1:0] wd;
  logic          rd_valid, wr_ready, ram_we;
  logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
  logic [LW-1:0] level;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  text_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
    .i_pix_clk(clk), .i_reset_n(rst_n),
    .i_horz_blank(hb), .i_vert_blank(vb),
    .i_vid_rd_req(req), .i_vid_rd_addr(raddr),
    .o_vid_rd_valid(rd_valid), .o_vid_rd_data(rd_data),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_addr(wa), .i_wr_data(wd), .i_flush(flush),
    .o_fifo_level(level), .o_ram_addr(ram_addr),
    .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  logic [DW-1:0] ram [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int due; logic [DW-1:0] d; } rd_t;

  wr_t           q[$];
  rd_t           pend[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] last_data;
  bit            m_ready;
  int            cyc;
  int            checks, errors;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic run_cycle();
    bit            w, exp_we;
    logic [AW-1:0] exp_addr;
    #1;
`ifdef VIDEO_IDLE_WRITE_EN
    w = hb | vb | !req;
`else
    w = hb | vb;
`endif
    exp_we   = rst_n && !req && q.size() > 0 && w && !flush;
    exp_addr = req ? raddr : (q.size() > 0 ? q[0].a : '0);
    chk("level", 32'(level), 32'(q.size()));
    chk("ready", 32'(wr_ready), 32'(m_ready));
    chk("we", 32'(ram_we), 32'(exp_we));
    chk("addr", 32'(ram_addr), 32'(exp_addr));
    if (exp_we) chk("wdata", 32'(ram_wdata), 32'(q[0].d));
    if (pend.size() > 0 && pend[0].due == cyc) begin
      chk("valid", 32'(rd_valid), 32'd1);
      chk("rdata", 32'(rd_data), 32'(pend[0].d));
      last_data = pend[0].d;
      void'(pend.pop_front());
    end else begin
      chk("valid", 32'(rd_valid), 32'd0);
      chk("hold", 32'(rd_data), 32'(last_data));
    end
    if (rst_n) begin
      if (req) pend.push_back('{cyc + 2, ref_mem[raddr]});
      if (exp_we) begin
        ref_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (wr_valid && m_ready) q.push_back('{wa, wd});
      m_ready = (q.size() != D);
    end
    cyc++;
  endtask

  task automatic set_idle();
    hb = 0; vb = 0; req = 0; wr_valid = 0; flush = 0;
    raddr = '0; wa = '0; wd = '0;
  endtask

  task automatic rand_inputs(input int p_blank, input int p_req,
                             input int p_wr, input int p_flush);
    hb       = ($urandom_range(99) < p_blank);
    vb       = ($urandom_range(99) < p_blank / 4);
    req      = ($urandom_range(99) < p_req);
    wr_valid = ($urandom_range(99) < p_wr);
    flush    = ($urandom_range(99) < p_flush);
    raddr    = AW'($urandom_range(15));
    wa       = AW'($urandom_range(15));
    wd       = DW'($urandom);
  endtask

  task automatic rand_phase(input int n, input int p_blank, input int p_req,
                            input int p_wr, input int p_flush);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rand_inputs(p_blank, p_req, p_wr, p_flush);
      run_cycle();
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    m_ready = 0; last_data = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = DW'($urandom);
      ref_mem[i] = ram[i];
    end
    rst_n = 1'b0;
    set_idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      run_cycle();
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycle();

    rand_phase(300, 10, 40, 80, 0);
    rand_phase(300, 50, 50, 50, 3);
    rand_phase(300, 90, 70, 90, 5);
    rand_phase(300, 30, 20, 60, 2);

    // queue three writes with no blank and a read in flight, then reset
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      set_idle();
      hb = 1'b1;
      run_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_idle();
      wr_valid = 1'b1;
      wa = AW'(16 + i);
      wd = DW'(8'h41 + i);
      run_cycle();
    end
    @(posedge clk); #1;
    set_idle();
    req = 1'b1;
    raddr = AW'(16);
    run_cycle();
    @(posedge clk); #1;
    set_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    q.delete();
    pend.delete();
    m_ready = 0;
    last_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      run_cycle();
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycle();

    rand_phase(400, 40, 50, 70, 4);

    @(posedge clk); #1;
    set_idle();
    hb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
